// File: rtl/axi_ic_pkg.sv
// Shared types and constants for the single-master AXI4-Lite interconnect.
// The optional slave timeout is enabled with the AXI_TIMEOUT_EN macro.
package axi_ic_pkg;

    localparam logic [31:0] UART_BASE_DEF   = 32'h2000_0000;
    localparam logic [31:0] PWM_BASE_DEF    = 32'h2000_1000;
    localparam logic [31:0] REGION_MASK_DEF = 32'hFFFF_F000;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int TIMEOUT_CYCLES = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_WR_XFER,
        ST_WR_RESP
    } state_t;

    typedef enum logic [1:0] {
        SEL_UART,
        SEL_PWM,
        SEL_NONE
    } sel_t;

    // Bit 0 is UART, bit 1 is PWM; NONE maps to no slave.
    function automatic logic [1:0] sel_onehot(input sel_t s);
        logic [1:0] oh;
        oh = 2'b00;
        unique case (s)
            SEL_UART: oh = 2'b01;
            SEL_PWM:  oh = 2'b10;
            default:  oh = 2'b00;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/axi4_lite_interconnect_decoder.sv
// Combinational address decoder: maps an address to UART, PWM or NONE.
// Instantiated once for the read path and once for the write path.
module axi_addr_decoder
    import axi_ic_pkg::*;
#(
    parameter logic [31:0] UART_BASE   = UART_BASE_DEF,
    parameter logic [31:0] PWM_BASE    = PWM_BASE_DEF,
    parameter logic [31:0] REGION_MASK = REGION_MASK_DEF
) (
    input  logic [31:0] i_addr,
    output sel_t        o_sel
);

    logic [31:0] w_region;

    assign w_region = i_addr & REGION_MASK;

    always_comb begin
        o_sel = SEL_NONE;
        unique case (1'b1)
            (w_region == UART_BASE): o_sel = SEL_UART;
            (w_region == PWM_BASE):  o_sel = SEL_PWM;
            default:                 o_sel = SEL_NONE;
        endcase
    end

endmodule

// File: rtl/axi4_lite_interconnect.sv
// AXI4-Lite 1-to-2 interconnect, one transaction in flight, local DECERR.
// Define AXI_TIMEOUT_EN for the slave watchdog with sticky dead bits.
module axi4_lite_interconnect
    import axi_ic_pkg::*;
#(
    parameter logic [31:0] UART_BASE   = UART_BASE_DEF,
    parameter logic [31:0] PWM_BASE    = PWM_BASE_DEF,
    parameter logic [31:0] REGION_MASK = REGION_MASK_DEF
) (
    input  logic        axi_aclk_i,
    input  logic        axi_aresetn_i,
    input  logic [31:0] araddr_i,
    input  logic [31:0] awaddr_i,
    input  logic        m_arvalid_i,
    output logic        m_arready_o,
    output logic        m_rvalid_o,
    input  logic        m_rready_i,
    output logic [31:0] m_rdata_o,
    output logic [1:0]  m_rresp_o,
    input  logic        m_awvalid_i,
    output logic        m_awready_o,
    input  logic        m_wvalid_i,
    output logic        m_wready_o,
    output logic        m_bvalid_o,
    input  logic        m_bready_i,
    output logic [1:0]  m_bresp_o,
    output logic [1:0]  s_arvalid_o,
    input  logic [1:0]  s_arready_i,
    input  logic [1:0]  s_rvalid_i,
    output logic [1:0]  s_rready_o,
    input  logic [63:0] s_rdata_i,
    output logic [1:0]  s_awvalid_o,
    input  logic [1:0]  s_awready_i,
    output logic [1:0]  s_wvalid_o,
    input  logic [1:0]  s_wready_i,
    input  logic [1:0]  s_bvalid_i,
    output logic [1:0]  s_bready_o
);

    state_t      r_state;
    state_t      w_state_nxt;
    sel_t        r_sel;
    sel_t        w_rd_sel;
    sel_t        w_wr_sel;
    sel_t        w_new_sel;
    logic        r_aw_done;
    logic        r_w_done;
    logic        w_aw_hs;
    logic        w_w_hs;
    logic        w_slv_hs;
    logic        w_local;
    logic [1:0]  w_lresp;
    logic [1:0]  w_oh;
    logic        w_s_arrdy;
    logic        w_s_rvld;
    logic        w_s_awrdy;
    logic        w_s_wrdy;
    logic        w_s_bvld;
    logic [31:0] w_s_rdata;

    axi_addr_decoder #(
        .UART_BASE   (UART_BASE),
        .PWM_BASE    (PWM_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_rd_dec (
        .i_addr (araddr_i),
        .o_sel  (w_rd_sel)
    );

    axi_addr_decoder #(
        .UART_BASE   (UART_BASE),
        .PWM_BASE    (PWM_BASE),
        .REGION_MASK (REGION_MASK)
    ) u_wr_dec (
        .i_addr (awaddr_i),
        .o_sel  (w_wr_sel)
    );

    assign w_new_sel = m_arvalid_i ? w_rd_sel : w_wr_sel;

`ifdef AXI_TIMEOUT_EN
    logic [7:0] r_wait;
    logic [1:0] r_dead;
    logic       r_tmo;
    logic       w_expire;
    logic       w_new_dead;

    // A timed-out or dead slave is completed locally, like an unmapped one.
    assign w_local    = (r_sel == SEL_NONE) || r_tmo;
    assign w_lresp    = (r_sel == SEL_NONE) ? RESP_DECERR : RESP_SLVERR;
    assign w_new_dead = |(r_dead & sel_onehot(w_new_sel));
    assign w_expire   = (r_state != ST_IDLE) && !w_local && !w_slv_hs &&
                        (r_wait == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge axi_aclk_i or negedge axi_aresetn_i) begin
        if (!axi_aresetn_i) begin
            r_wait <= '0;
            r_dead <= '0;
            r_tmo  <= 1'b0;
        end else begin
            if ((r_state == ST_IDLE) || w_slv_hs || w_expire)
                r_wait <= '0;
            else
                r_wait <= r_wait + 8'd1;
            if (r_state == ST_IDLE)
                r_tmo <= w_new_dead;
            else if (w_expire)
                r_tmo <= 1'b1;
            if (w_expire)
                r_dead <= r_dead | sel_onehot(r_sel);
        end
    end
`else
    assign w_local = (r_sel == SEL_NONE);
    assign w_lresp = RESP_DECERR;
`endif

    assign w_oh      = w_local ? 2'b00 : sel_onehot(r_sel);
    assign w_s_arrdy = |(s_arready_i & w_oh);
    assign w_s_rvld  = |(s_rvalid_i & w_oh);
    assign w_s_awrdy = |(s_awready_i & w_oh);
    assign w_s_wrdy  = |(s_wready_i & w_oh);
    assign w_s_bvld  = |(s_bvalid_i & w_oh);
    assign w_s_rdata = w_oh[1] ? s_rdata_i[63:32] :
                       w_oh[0] ? s_rdata_i[31:0]  : 32'h0;

    always_ff @(posedge axi_aclk_i or negedge axi_aresetn_i) begin
        if (!axi_aresetn_i) begin
            r_state   <= ST_IDLE;
            r_sel     <= SEL_NONE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE)
                r_sel <= w_new_sel;
            if (w_state_nxt == ST_IDLE) begin
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else begin
                r_aw_done <= r_aw_done | w_aw_hs;
                r_w_done  <= r_w_done | w_w_hs;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_aw_hs     = 1'b0;
        w_w_hs      = 1'b0;
        w_slv_hs    = 1'b0;
        m_arready_o = 1'b0;
        m_rvalid_o  = 1'b0;
        m_rdata_o   = 32'h0;
        m_rresp_o   = RESP_OKAY;
        m_awready_o = 1'b0;
        m_wready_o  = 1'b0;
        m_bvalid_o  = 1'b0;
        m_bresp_o   = RESP_OKAY;
        s_arvalid_o = 2'b00;
        s_rready_o  = 2'b00;
        s_awvalid_o = 2'b00;
        s_wvalid_o  = 2'b00;
        s_bready_o  = 2'b00;
        unique case (r_state)
            ST_IDLE: begin
                if (m_arvalid_i)
                    w_state_nxt = ST_RD_ADDR;
                else if (m_awvalid_i)
                    w_state_nxt = ST_WR_XFER;
            end
            ST_RD_ADDR: begin
                if (w_local) begin
                    m_arready_o = 1'b1;
                    w_state_nxt = ST_RD_DATA;
                end else begin
                    s_arvalid_o = w_oh;
                    m_arready_o = w_s_arrdy;
                    if (w_s_arrdy) begin
                        w_slv_hs    = 1'b1;
                        w_state_nxt = ST_RD_DATA;
                    end
                end
            end
            ST_RD_DATA: begin
                if (w_local) begin
                    m_rvalid_o = 1'b1;
                    m_rresp_o  = w_lresp;
                end else begin
                    m_rvalid_o = w_s_rvld;
                    m_rdata_o  = w_s_rdata;
                    s_rready_o = w_oh & {2{m_rready_i}};
                    w_slv_hs   = w_s_rvld & m_rready_i;
                end
                if (m_rvalid_o && m_rready_i)
                    w_state_nxt = ST_IDLE;
            end
            ST_WR_XFER: begin
                // AW and W complete independently; each valid drops once done.
                if (!r_aw_done) begin
                    m_awready_o = w_local ? 1'b1 : w_s_awrdy;
                    s_awvalid_o = w_oh & {2{m_awvalid_i}};
                    w_aw_hs     = m_awvalid_i & m_awready_o;
                end
                if (!r_w_done) begin
                    m_wready_o = w_local ? 1'b1 : w_s_wrdy;
                    s_wvalid_o = w_oh & {2{m_wvalid_i}};
                    w_w_hs     = m_wvalid_i & m_wready_o;
                end
                w_slv_hs = !w_local && (w_aw_hs || w_w_hs);
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
                    w_state_nxt = ST_WR_RESP;
            end
            ST_WR_RESP: begin
                if (w_local) begin
                    m_bvalid_o = 1'b1;
                    m_bresp_o  = w_lresp;
                end else begin
                    m_bvalid_o = w_s_bvld;
                    s_bready_o = w_oh & {2{m_bready_i}};
                    w_slv_hs   = w_s_bvld & m_bready_i;
                end
                if (m_bvalid_o && m_bready_i)
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule

// File: doc/axi4_lite_interconnect.md
# axi4_lite_interconnect
Single-master, two-slave AXI4-Lite interconnect. It sits between `axi_master` and the UART and PWM slaves. It decodes each transaction address, steers valid/ready to exactly one slave, and serialises reads and writes so only one transaction is in flight. It returns a local DECERR response for unmapped addresses, so no slave ever responds to a foreign address.
## Interface
- UART_BASE, 32'h2000_0000, base of UART region
- PWM_BASE, 32'h2000_1000, base of PWM region
- REGION_MASK, 32'hFFFF_F000, bits compared against each base (4 KiB regions)
- axi_aclk_i  in  1  clock
- axi_aresetn_i  in  1  asynchronous active-low reset
- araddr_i / awaddr_i  in  32 each  master read/write address (decode only; address and data buses are broadcast to slaves outside this block)
- m_arvalid_i  in  1 / m_arready_o  out  1  master read-address handshake
- m_rvalid_o  out  1 / m_rready_i  in  1  master read-data handshake
- m_rdata_o  out  32  read data to master
- m_rresp_o  out  2  read response: 00 OKAY, 10 SLVERR, 11 DECERR
- m_awvalid_i  in  1 / m_awready_o  out  1  master write-address handshake
- m_wvalid_i  in  1 / m_wready_o  out  1  master write-data handshake
- m_bvalid_o  out  1 / m_bready_i  in  1  master write-response handshake
- m_bresp_o  out  2  write response, same encoding as m_rresp_o
- s_arvalid_o  out  2 / s_arready_i  in  2  per-slave read address; bit0 UART, bit1 PWM
- s_rvalid_i  in  2 / s_rready_o  out  2  per-slave read data
- s_rdata_i  in  64  {PWM rdata, UART rdata}
- s_awvalid_o  out  2 / s_awready_i  in  2  per-slave write address
- s_wvalid_o  out  2 / s_wready_i  in  2  per-slave write data
- s_bvalid_i  in  2 / s_bready_o  out  2  per-slave write response
## Operation
- States: IDLE, RD_ADDR, RD_DATA, WR_XFER, WR_RESP.
- **IDLE:**
  - m_arvalid_i high: latch the decoded select (UART, PWM or NONE) from araddr_i and go to RD_ADDR.
  - Otherwise, m_awvalid_i high: latch the select from awaddr_i and go to WR_XFER.
  - Both high in the same cycle: read wins; the write waits.
- **RD_ADDR:**
  - Mapped: s_arvalid_o[sel]=1 and m_arready_o=s_arready_i[sel]. On the handshake go to RD_DATA.
  - NONE: m_arready_o=1 for one cycle, then RD_DATA.
- **RD_DATA:**
  - Mapped: m_rvalid_o=s_rvalid_i[sel], s_rready_o[sel]=m_rready_i, m_rdata_o=s_rdata_i[sel], m_rresp_o=00.
  - NONE: m_rvalid_o=1, rdata 0, rresp 11.
  - On the handshake go to IDLE.
- **WR_XFER:**
  - AW and W are forwarded independently to sel (or acked locally if NONE).
  - Sticky aw_done and w_done flags record each handshake; each valid drops once its flag is set.
  - Both flags set: go to WR_RESP.
- **WR_RESP:**
  - b channel forwarded like RD_DATA; NONE gives bvalid=1, bresp=11.
  - On the handshake go to IDLE and clear both flags.
- Non-selected slave bits are always 0. At most one s_*valid_o bit is high in any cycle.
## Timing
- Reset: every output is 0 and the state is IDLE, asynchronously. A reset mid-transaction discards it with no response.
- Master valids are sampled in IDLE. The first s_arvalid_o/s_awvalid_o asserts 1 cycle later. Ready/valid/data pass-throughs in RD_ADDR, RD_DATA, WR_XFER and WR_RESP are combinational from the slave.
- Minimum mapped read: m_arvalid_i @0, s_arvalid_o @1, m_rvalid_o @2 if the slave answers immediately, IDLE @3.
- Unmapped read: m_arready_o @1, m_rvalid_o @2.
- Address must stay stable while valid is high (AXI rule); select is latched once per transaction.
## Configuration
- **AXI_TIMEOUT_EN defined:**
  - An 8-bit wait counter runs in RD_ADDR, RD_DATA, WR_XFER and WR_RESP while the slave has not handshaken. It resets on every slave handshake.
  - At 256 cycles the block completes to the master locally with resp 10 (SLVERR), rdata 0, and sets a sticky per-slave dead bit.
  - Later accesses to a dead slave get SLVERR locally with NONE timing. Dead bits clear only on reset.
- **Undefined:** no counter and no dead bits; the block waits indefinitely.
## Structure
- Shared package `axi_ic_pkg`: state enum, select enum (SEL_UART, SEL_PWM, SEL_NONE), RESP_OKAY/SLVERR/DECERR constants, TIMEOUT_CYCLES=256.
- One sub-module, `axi_addr_decoder`: combinational addr → select using the base and mask parameters. It is instantiated twice, once for reads and once for writes.
## Test plan
- Read 0x2000_0004, UART arready 1 cycle late, rdata 0x0000_0041 → m_rdata_o 0x41, rresp 00; s_arvalid_o never 2'b10.
- Write 0x2000_1000 data 0x64, PWM awready 2 cycles before wready → s_awvalid_o and s_wvalid_o each deassert after their own handshake; one bvalid, bresp 00.
- Read 0x3000_0000 → m_arready_o @1, m_rvalid_o @2, rdata 0, rresp 11; no s_*valid_o bit ever asserted.
- m_arvalid_i and m_awvalid_i together @0 for UART → read completes first, then the write; writes hold until the read handshake.
- Reset pulse during RD_DATA → all outputs 0 immediately, state IDLE; next read to PWM returns correct data.
- With AXI_TIMEOUT_EN, PWM never asserts rvalid → rresp 10 after 256 cycles; next PWM read gives SLVERR @2; a UART read still gives OKAY.
